// File: rtl/swire_power_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// swire_power_sequencer : ordered multi-channel power-up / power-down sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
module swire_power_sequencer #(
  parameter int                      NUM_CH     = 2,
  parameter int                      CNT_W      = 24,
  parameter logic [NUM_CH*CNT_W-1:0] UP_DLY     = {24'h30, 24'h30},
  parameter logic [NUM_CH*CNT_W-1:0] DN_DLY     = {24'h10, 24'h10},
  parameter bit                      AUTO_START = 1'b1,
  parameter int                      IDX_W      = 4
) (
  input  logic              i_clk_38m,
  input  logic              i_reset_n,
  input  logic              i_enable,
  output logic [NUM_CH-1:0] o_start,
  output logic              o_seq_busy,
  output logic              o_seq_done,
  output logic [IDX_W-1:0]  o_stage
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [NUM_CH-1:0]   start;
  logic                done;

  logic                en_eff;
  logic [CNT_W-1:0]    up_dly [NUM_CH];
  logic [CNT_W-1:0]    dn_dly [NUM_CH];
  logic [CNT_W-1:0]    up_cur;
  logic [CNT_W-1:0]    dn_cur;
  logic [NUM_CH-1:0]   sel;
  logic [IDX_W-1:0]    hi_idx;

  assign en_eff = AUTO_START ? 1'b1 : i_enable;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dly
    assign up_dly[g] = UP_DLY[g*CNT_W +: CNT_W];
    assign dn_dly[g] = DN_DLY[g*CNT_W +: CNT_W];
  end

  // Channel select, delay lookup and highest-asserted encoder, all keyed by idx
  always_comb begin
    up_cur = '0;
    dn_cur = '0;
    sel    = '0;
    hi_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) begin
        up_cur = up_dly[i];
        dn_cur = dn_dly[i];
        sel[i] = 1'b1;
      end
      if (start[i]) begin
        hi_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk_38m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_OFF;
      cnt   <= '0;
      idx   <= '0;
      start <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          if (en_eff) begin
            state <= S_UP;
            idx   <= '0;
            cnt   <= '0;
          end
        end

        S_UP: begin
          // An abort wins over a match on the same edge
          if (!en_eff) begin
            if (start == '0) begin
              state <= S_OFF;
              idx   <= '0;
            end else begin
              state <= S_DOWN;
              idx   <= hi_idx;
              cnt   <= '0;
            end
          end else if (cnt == up_cur) begin
            start <= start | sel;
            cnt   <= '0;
            if (idx == LAST_IDX) begin
              state <= S_ON;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_ON: begin
          if (!en_eff) begin
            state <= S_DOWN;
            done  <= 1'b0;
            idx   <= LAST_IDX;
            cnt   <= '0;
          end
        end

        S_DOWN: begin
          // Runs to completion regardless of en_eff
          if (cnt == dn_cur) begin
            start <= start & ~sel;
            cnt   <= '0;
            if (idx == '0) begin
              state <= S_OFF;
            end else begin
              idx <= idx - IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_OFF;
          cnt   <= '0;
          idx   <= '0;
          start <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_start    = start;
  assign o_seq_done = done;
  assign o_stage    = idx;
  assign o_seq_busy = (state == S_UP) || (state == S_DOWN);

endmodule
`default_nettype wire

// File: tb/tb_swire_power_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_swire_power_sequencer : directed self-checking bench, three configurations
// Revision 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_swire_power_sequencer;

  logic clk = 1'b0;
  always #13 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       en_a, en_b, en_c;

  logic [2:0] start_a;
  logic       busy_a, done_a;
  logic [3:0] stage_a;

  logic [2:0] start_b;
  logic       busy_b, done_b;
  logic [3:0] stage_b;

  logic [0:0] start_c;
  logic       busy_c, done_c;
  logic [3:0] stage_c;

  int checks = 0;
  int fails  = 0;

  swire_power_sequencer #(
    .NUM_CH(3), .CNT_W(24),
    .UP_DLY({24'd5, 24'd3, 24'd0}),
    .DN_DLY({24'd2, 24'd2, 24'd2}),
    .AUTO_START(1'b0), .IDX_W(4)
  ) dut_a (
    .i_clk_38m(clk), .i_reset_n(rst_a), .i_enable(en_a),
    .o_start(start_a), .o_seq_busy(busy_a), .o_seq_done(done_a), .o_stage(stage_a)
  );

  swire_power_sequencer #(
    .NUM_CH(3), .CNT_W(24),
    .UP_DLY({24'd5, 24'd3, 24'd4}),
    .DN_DLY({24'd2, 24'd2, 24'd2}),
    .AUTO_START(1'b0), .IDX_W(4)
  ) dut_b (
    .i_clk_38m(clk), .i_reset_n(rst_b), .i_enable(en_b),
    .o_start(start_b), .o_seq_busy(busy_b), .o_seq_done(done_b), .o_stage(stage_b)
  );

  swire_power_sequencer #(
    .NUM_CH(1), .CNT_W(24),
    .UP_DLY(24'h30),
    .DN_DLY(24'h10),
    .AUTO_START(1'b1), .IDX_W(4)
  ) dut_c (
    .i_clk_38m(clk), .i_reset_n(rst_c), .i_enable(en_c),
    .o_start(start_c), .o_seq_busy(busy_c), .o_seq_done(done_c), .o_stage(stage_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if ({start_a, busy_a, done_a, stage_a} !== 9'b0) begin fails++;
      $display("FAIL reset_a got start=%b busy=%b done=%b stage=%0d want all 0", start_a, busy_a, done_a, stage_a); end
    checks++; if ({start_b, busy_b, done_b, stage_b} !== 9'b0) begin fails++;
      $display("FAIL reset_b got start=%b busy=%b done=%b stage=%0d want all 0", start_b, busy_b, done_b, stage_b); end
    checks++; if ({start_c, busy_c, done_c, stage_c} !== 7'b0) begin fails++;
      $display("FAIL reset_c got start=%b busy=%b done=%b stage=%0d want all 0", start_c, busy_c, done_c, stage_c); end
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    checks++; if ({start_a, busy_a, done_a, stage_a} !== 9'b0) begin fails++;
      $display("FAIL idle_off got start=%b busy=%b done=%b stage=%0d want all 0", start_a, busy_a, done_a, stage_a); end
  endtask

  task automatic test_up;
    logic [2:0] es;
    logic [3:0] et;
    en_a = 1'b1;
    tick();
    checks++; if (busy_a !== 1'b1 || start_a !== 3'b000 || stage_a !== 4'd0) begin fails++;
      $display("FAIL up_entry got busy=%b start=%b stage=%0d want 1 000 0", busy_a, start_a, stage_a); end
    for (int k = 1; k <= 11; k++) begin
      tick();
      es = (k >= 11) ? 3'b111 : (k >= 5) ? 3'b011 : 3'b001;
      et = (k >= 5) ? 4'd2 : 4'd1;
      checks++; if (start_a !== es) begin fails++;
        $display("FAIL up_start E0+%0d got %b want %b", k, start_a, es); end
      checks++; if (stage_a !== et) begin fails++;
        $display("FAIL up_stage E0+%0d got %0d want %0d", k, stage_a, et); end
      checks++; if (busy_a !== (k <= 10) || done_a !== (k >= 11)) begin fails++;
        $display("FAIL up_flags E0+%0d got busy=%b done=%b want %b %b", k, busy_a, done_a, k <= 10, k >= 11); end
    end
  endtask

  task automatic test_down;
    logic [2:0] es;
    logic [3:0] et;
    tick();
    tick();
    checks++; if (done_a !== 1'b1 || start_a !== 3'b111 || busy_a !== 1'b0) begin fails++;
      $display("FAIL on_hold got done=%b start=%b busy=%b want 1 111 0", done_a, start_a, busy_a); end
    en_a = 1'b0;
    tick();
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b1 || stage_a !== 4'd2 || start_a !== 3'b111) begin fails++;
      $display("FAIL down_entry got done=%b busy=%b stage=%0d start=%b want 0 1 2 111", done_a, busy_a, stage_a, start_a); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      es = (k >= 9) ? 3'b000 : (k >= 6) ? 3'b001 : (k >= 3) ? 3'b011 : 3'b111;
      et = (k >= 6) ? 4'd0 : (k >= 3) ? 4'd1 : 4'd2;
      checks++; if (start_a !== es || stage_a !== et) begin fails++;
        $display("FAIL down_seq D0+%0d got start=%b stage=%0d want %b %0d", k, start_a, stage_a, es, et); end
      checks++; if (busy_a !== (k < 9) || done_a !== 1'b0) begin fails++;
        $display("FAIL down_flags D0+%0d got busy=%b done=%b want %b 0", k, busy_a, done_a, k < 9); end
    end
  endtask

  task automatic test_abort;
    logic [2:0] es;
    logic [3:0] et;
    en_a = 1'b1;
    tick();
    repeat (6) tick();
    checks++; if (start_a !== 3'b011 || stage_a !== 4'd2) begin fails++;
      $display("FAIL abort_pre got start=%b stage=%0d want 011 2", start_a, stage_a); end
    en_a = 1'b0;
    tick();
    checks++; if (start_a !== 3'b011 || stage_a !== 4'd1 || busy_a !== 1'b1) begin fails++;
      $display("FAIL abort_entry got start=%b stage=%0d busy=%b want 011 1 1", start_a, stage_a, busy_a); end
    for (int k = 8; k <= 13; k++) begin
      tick();
      es = (k >= 13) ? 3'b000 : (k >= 10) ? 3'b001 : 3'b011;
      et = (k >= 10) ? 4'd0 : 4'd1;
      checks++; if (start_a !== es || stage_a !== et) begin fails++;
        $display("FAIL abort_seq E0+%0d got start=%b stage=%0d want %b %0d", k, start_a, stage_a, es, et); end
      checks++; if (busy_a !== (k < 13) || done_a !== 1'b0) begin fails++;
        $display("FAIL abort_flags E0+%0d got busy=%b done=%b want %b 0", k, busy_a, done_a, k < 13); end
    end
  endtask

  task automatic test_early_abort;
    en_b = 1'b1;
    tick();
    checks++; if (busy_b !== 1'b1 || start_b !== 3'b000) begin fails++;
      $display("FAIL early_entry got busy=%b start=%b want 1 000", busy_b, start_b); end
    en_b = 1'b0;
    tick();
    checks++; if (busy_b !== 1'b0 || start_b !== 3'b000 || stage_b !== 4'd0 || done_b !== 1'b0) begin fails++;
      $display("FAIL early_off got busy=%b start=%b stage=%0d done=%b want 0 000 0 0", busy_b, start_b, stage_b, done_b); end
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++; if (start_b !== 3'b000 || busy_b !== 1'b0) begin fails++;
        $display("FAIL early_stay E0+%0d got start=%b busy=%b want 000 0", k, start_b, busy_b); end
    end
  endtask

  task automatic test_reenable_reset;
    en_a = 1'b1;
    tick();
    repeat (11) tick();
    checks++; if (done_a !== 1'b1 || start_a !== 3'b111) begin fails++;
      $display("FAIL re_on got done=%b start=%b want 1 111", done_a, start_a); end
    en_a = 1'b0;
    tick();
    repeat (3) tick();
    en_a = 1'b1;
    repeat (5) tick();
    checks++; if (start_a !== 3'b001 || busy_a !== 1'b1 || stage_a !== 4'd0) begin fails++;
      $display("FAIL re_down D0+8 got start=%b busy=%b stage=%0d want 001 1 0", start_a, busy_a, stage_a); end
    tick();
    checks++; if (start_a !== 3'b000 || busy_a !== 1'b0 || done_a !== 1'b0) begin fails++;
      $display("FAIL re_off D0+9 got start=%b busy=%b done=%b want 000 0 0", start_a, busy_a, done_a); end
    tick();
    checks++; if (busy_a !== 1'b1 || stage_a !== 4'd0 || start_a !== 3'b000) begin fails++;
      $display("FAIL re_up D0+10 got busy=%b stage=%0d start=%b want 1 0 000", busy_a, stage_a, start_a); end
    tick();
    checks++; if (start_a !== 3'b001 || stage_a !== 4'd1) begin fails++;
      $display("FAIL re_ch0 D0+11 got start=%b stage=%0d want 001 1", start_a, stage_a); end
    tick();
    #5 rst_a = 1'b0;
    #1;
    checks++; if ({start_a, busy_a, done_a, stage_a} !== 9'b0) begin fails++;
      $display("FAIL async_rst got start=%b busy=%b done=%b stage=%0d want all 0", start_a, busy_a, done_a, stage_a); end
    tick();
    checks++; if ({start_a, busy_a, done_a, stage_a} !== 9'b0) begin fails++;
      $display("FAIL rst_hold got start=%b busy=%b done=%b stage=%0d want all 0", start_a, busy_a, done_a, stage_a); end
    en_a  = 1'b0;
    rst_a = 1'b1;
  endtask

  task automatic test_legacy;
    en_c  = 1'b0;
    rst_c = 1'b1;
    tick();
    checks++; if (busy_c !== 1'b1 || start_c !== 1'b0) begin fails++;
      $display("FAIL legacy_entry got busy=%b start=%b want 1 0", busy_c, start_c); end
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k == 48) begin
        checks++; if (start_c !== 1'b0 || done_c !== 1'b0) begin fails++;
          $display("FAIL legacy_early entry+48 got start=%b done=%b want 0 0", start_c, done_c); end
      end
      if (k == 49) begin
        checks++; if (start_c !== 1'b1 || done_c !== 1'b1 || busy_c !== 1'b0) begin fails++;
          $display("FAIL legacy_rise entry+49 got start=%b done=%b busy=%b want 1 1 0", start_c, done_c, busy_c); end
      end
    end
    repeat (20) tick();
    checks++; if (start_c !== 1'b1 || done_c !== 1'b1 || stage_c !== 4'd0) begin fails++;
      $display("FAIL legacy_hold got start=%b done=%b stage=%0d want 1 1 0", start_c, done_c, stage_c); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0;
    test_reset();
    test_up();
    test_down();
    test_abort();
    test_early_abort();
    test_reenable_reset();
    test_legacy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
